// File: rtl/ps2_kbd_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: frame FSM states,
// scancodes, status-word field positions and a key classification helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;

    localparam int WORD_LEFT_BIT   = 0;
    localparam int WORD_RIGHT_BIT  = 1;
    localparam int WORD_SPACE_BIT  = 2;
    localparam int WORD_CODE_LSB   = 8;
    localparam int WORD_ERRCNT_LSB = 16;

    typedef enum logic [2:0] {
        KEY_NONE,
        KEY_LEFT,
        KEY_RIGHT,
        KEY_SPACE,
        KEY_A,
        KEY_D
    } key_e;

    // Letter keys are always recognised here; the receiver decides whether to act on them.
    function automatic key_e classify_key(input logic ext, input logic [7:0] code);
        key_e k;
        k = KEY_NONE;
        if (ext) begin
            if (code == SC_LEFT)
                k = KEY_LEFT;
            else if (code == SC_RIGHT)
                k = KEY_RIGHT;
        end else begin
            if (code == SC_SPACE)
                k = KEY_SPACE;
            else if (code == SC_A)
                k = KEY_A;
            else if (code == SC_D)
                k = KEY_D;
        end
        return k;
    endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Bundle of PS/2 pin inputs and receiver status outputs; slave is the receiver side,
// master is whatever drives the pins and consumes the status.
interface ps2_kbd_rx_if;

    logic        ps2_clk_i;
    logic        ps2_dat_i;
    logic [31:0] ps2_word;
    logic        code_valid;
    logic [7:0]  code;
    logic        frame_err;

    modport master (
        output ps2_clk_i,
        output ps2_dat_i,
        input  ps2_word,
        input  code_valid,
        input  code,
        input  frame_err
    );

    modport slave (
        input  ps2_clk_i,
        input  ps2_dat_i,
        output ps2_word,
        output code_valid,
        output code,
        output frame_err
    );

endinterface

// File: rtl/ps2_kbd_rx_sync_edge.sv
// Synchronizes the raw PS/2 clock and data pins and flags the falling edge of the
// synchronized PS/2 clock as a one-cycle strobe.
module ps2_sync_edge
    import ps2_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_ps2_clk,
    input  logic i_ps2_dat,
    output logic o_dat,
    output logic o_fe
);

    // Fewer than two stages would not protect against metastability.
    localparam int N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] r_clk_sync;
    logic [N-1:0] r_dat_sync;
    logic         r_clk_prev;

    // Clearing to 0 means a line that is already high after reset looks like a rising edge, never a falling one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_sync <= '0;
            r_dat_sync <= '0;
            r_clk_prev <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[N-2:0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[N-2:0], i_ps2_dat};
            r_clk_prev <= r_clk_sync[N-1];
        end
    end

    assign o_fe  = r_clk_prev & ~r_clk_sync[N-1];
    assign o_dat = r_dat_sync[N-1];

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frames 11-bit device-to-host words and tracks arrow/space keys
// in a 32-bit status word. Define PS2_KBD_WASD_EN to let A/D also drive left/right.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic          clk,
    input  logic          reset,
    ps2_kbd_rx_if.slave   bus
);

    localparam int                TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic w_dat;
    logic w_fe;

    state_e          r_state;
    state_e          w_state_next;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_parity;
    logic [TO_W-1:0] r_to_cnt;

    logic w_start;
    logic w_shift_en;
    logic w_par_en;
    logic w_good;
    logic w_bad;
    logic w_timeout;

    logic       r_code_valid;
    logic       r_frame_err;
    logic [7:0] r_code;

    logic       r_ext;
    logic       r_brk;
    logic       r_left_arrow;
    logic       r_right_arrow;
    logic       r_space;
    logic [7:0] r_last_code;
    logic [7:0] r_err_cnt;
    key_e       w_key;
    logic       w_left;
    logic       w_right;
    logic [31:0] w_word;

`ifdef PS2_KBD_WASD_EN
    logic r_left_a;
    logic r_right_d;
`endif

    ps2_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .i_ps2_clk (bus.ps2_clk_i),
        .i_ps2_dat (bus.ps2_dat_i),
        .o_dat     (w_dat),
        .o_fe      (w_fe)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    // A timeout wins only when no edge arrives in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_shift_en   = 1'b0;
        w_par_en     = 1'b0;
        w_good       = 1'b0;
        w_bad        = 1'b0;
        w_timeout    = 1'b0;
        if (r_state != IDLE && !w_fe && r_to_cnt == TO_LAST) begin
            w_timeout    = 1'b1;
            w_state_next = IDLE;
        end else if (w_fe) begin
            case (r_state)
                IDLE: begin
                    if (!w_dat) begin
                        w_start      = 1'b1;
                        w_state_next = DATA;
                    end
                end
                DATA: begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 3'd7)
                        w_state_next = PARITY;
                end
                PARITY: begin
                    w_par_en     = 1'b1;
                    w_state_next = STOP;
                end
                STOP: begin
                    w_state_next = IDLE;
                    if (w_dat && (^{r_shift, r_parity}))
                        w_good = 1'b1;
                    else
                        w_bad = 1'b1;
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_parity  <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            if (w_start) begin
                r_bit_cnt <= 3'd0;
                r_shift   <= 8'h00;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_shift   <= {w_dat, r_shift[7:1]};
            end
            if (w_par_en)
                r_parity <= w_dat;
            if (r_state == IDLE || w_fe || w_timeout)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_code       <= 8'h00;
        end else begin
            r_code_valid <= w_good;
            r_frame_err  <= w_bad | w_timeout;
            if (w_good)
                r_code <= r_shift;
        end
    end

    assign w_key = classify_key(r_ext, r_code);

    // Any frame error, including a timeout, drops a pending E0/F0 prefix.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ext         <= 1'b0;
            r_brk         <= 1'b0;
            r_left_arrow  <= 1'b0;
            r_right_arrow <= 1'b0;
            r_space       <= 1'b0;
            r_last_code   <= 8'h00;
            r_err_cnt     <= 8'h00;
`ifdef PS2_KBD_WASD_EN
            r_left_a      <= 1'b0;
            r_right_d     <= 1'b0;
`endif
        end else if (r_frame_err) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
            if (r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;
        end else if (r_code_valid) begin
            if (r_code == SC_EXT) begin
                r_ext <= 1'b1;
            end else if (r_code == SC_BRK) begin
                r_brk <= 1'b1;
            end else begin
                r_ext       <= 1'b0;
                r_brk       <= 1'b0;
                r_last_code <= r_code;
                case (w_key)
                    KEY_LEFT:  r_left_arrow  <= ~r_brk;
                    KEY_RIGHT: r_right_arrow <= ~r_brk;
                    KEY_SPACE: r_space       <= ~r_brk;
`ifdef PS2_KBD_WASD_EN
                    KEY_A:     r_left_a      <= ~r_brk;
                    KEY_D:     r_right_d     <= ~r_brk;
`endif
                    default: ;
                endcase
            end
        end
    end

`ifdef PS2_KBD_WASD_EN
    assign w_left  = r_left_arrow | r_left_a;
    assign w_right = r_right_arrow | r_right_d;
`else
    assign w_left  = r_left_arrow;
    assign w_right = r_right_arrow;
`endif

    always_comb begin
        w_word                              = 32'h0000_0000;
        w_word[WORD_LEFT_BIT]               = w_left;
        w_word[WORD_RIGHT_BIT]              = w_right;
        w_word[WORD_SPACE_BIT]              = r_space;
        w_word[WORD_CODE_LSB +: 8]          = r_last_code;
        w_word[WORD_ERRCNT_LSB +: 8]        = r_err_cnt;
    end

    assign bus.ps2_word   = w_word;
    assign bus.code_valid = r_code_valid;
    assign bus.code       = r_code;
    assign bus.frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: drives PS/2 frames on the pins, scoreboards the
// code_valid/frame_err pulses and checks the status word after each key sequence.
module tb_ps2_kbd_rx;

    localparam int TO   = 400;
    localparam int HALF = 40;

    typedef struct {
        bit         isErr;
        logic [7:0] code;
    } event_t;

    logic   clk = 1'b0;
    logic   reset;
    event_t expQ[$];
    int     checks = 0;
    int     passes = 0;

    always #5 clk = ~clk;

    ps2_kbd_rx_if bus();

    ps2_kbd_rx #(
        .TIMEOUT_CYCLES (TO),
        .SYNC_STAGES    (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected)
            passes++;
        else
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic sendBit(input logic b);
        bus.ps2_dat_i = b;
        waitCycles(HALF / 2);
        bus.ps2_clk_i = 1'b0;
        waitCycles(HALF);
        bus.ps2_clk_i = 1'b1;
        waitCycles(HALF / 2);
    endtask

    // Odd parity; badParity flips the parity bit so the frame must be rejected.
    task automatic applyStimulus(input logic [7:0] data, input bit badParity);
        event_t e;
        logic   par;
        par     = ~(^data) ^ badParity;
        e.isErr = badParity;
        e.code  = badParity ? 8'h00 : data;
        expQ.push_back(e);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++)
            sendBit(data[i]);
        sendBit(par);
        sendBit(1'b1);
        bus.ps2_dat_i = 1'b1;
        waitCycles(40);
    endtask

    task automatic drain(input string tag);
        waitCycles(100);
        checkOutput({tag, "_drain"}, 32'(expQ.size()), 32'd0);
        #1;
    endtask

    // Scoreboard: every pulse must match the oldest outstanding expectation.
    initial begin
        event_t e;
        forever begin
            @(negedge clk);
            if (!reset && (bus.code_valid || bus.frame_err)) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_event", {22'b0, bus.frame_err, bus.code_valid, bus.code}, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("frame_err_pulse", {31'b0, bus.frame_err}, {31'b0, e.isErr});
                    checkOutput("code_valid_pulse", {31'b0, bus.code_valid}, {31'b0, !e.isErr});
                    if (!e.isErr)
                        checkOutput("code", {24'b0, bus.code}, {24'b0, e.code});
                end
            end
        end
    end

    initial begin
        event_t e;
        reset         = 1'b1;
        bus.ps2_clk_i = 1'b1;
        bus.ps2_dat_i = 1'b1;
        waitCycles(3);
        #1;
        checkOutput("reset_word", bus.ps2_word, 32'h0);
        checkOutput("reset_code", {24'b0, bus.code}, 32'h0);
        checkOutput("reset_valid", {31'b0, bus.code_valid}, 32'h0);
        checkOutput("reset_err", {31'b0, bus.frame_err}, 32'h0);
        reset = 1'b0;
        waitCycles(10);

        applyStimulus(8'hE0, 1'b0);
        applyStimulus(8'h6B, 1'b0);
        drain("make_left");
        checkOutput("make_left_word", bus.ps2_word, 32'h00006B01);

        applyStimulus(8'hE0, 1'b0);
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h6B, 1'b0);
        drain("break_left");
        checkOutput("break_left_word", bus.ps2_word, 32'h00006B00);
        checkOutput("break_left_code", {24'b0, bus.code}, 32'h0000006B);

        applyStimulus(8'hE0, 1'b0);
        applyStimulus(8'h6B, 1'b0);
        applyStimulus(8'hE0, 1'b0);
        applyStimulus(8'h74, 1'b0);
        applyStimulus(8'h29, 1'b0);
        drain("all_keys");
        checkOutput("all_keys_word", bus.ps2_word, 32'h00002907);

        // 0x6B already has an odd number of ones, so its correct parity bit is 0.
        applyStimulus(8'h6B, 1'b1);
        drain("bad_parity");
        checkOutput("bad_parity_word", bus.ps2_word, 32'h00012907);

        e.isErr = 1'b1;
        e.code  = 8'h00;
        expQ.push_back(e);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b1);
        sendBit(1'b0);
        bus.ps2_dat_i = 1'b1;
        waitCycles(TO + 100);
        drain("timeout");
        checkOutput("timeout_word", bus.ps2_word, 32'h00022907);
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h29, 1'b0);
        drain("after_timeout");
        checkOutput("after_timeout_word", bus.ps2_word, 32'h00022903);
        checkOutput("after_timeout_code", {24'b0, bus.code}, 32'h00000029);

        // 0xF0 split after five data bits; the tail (1,1,1, parity 1, stop 1) is all ones.
        sendBit(1'b0);
        for (int i = 0; i < 5; i++)
            sendBit(i == 4);
        reset = 1'b1;
        #1;
        checkOutput("midreset_word", bus.ps2_word, 32'h0);
        checkOutput("midreset_code", {24'b0, bus.code}, 32'h0);
        checkOutput("midreset_valid", {31'b0, bus.code_valid}, 32'h0);
        checkOutput("midreset_err", {31'b0, bus.frame_err}, 32'h0);
        waitCycles(5);
        reset = 1'b0;
        for (int i = 0; i < 5; i++)
            sendBit(1'b1);
        drain("midreset_tail");
        checkOutput("midreset_tail_word", bus.ps2_word, 32'h0);
        applyStimulus(8'hE0, 1'b0);
        applyStimulus(8'h74, 1'b0);
        drain("after_reset");
        checkOutput("after_reset_word", bus.ps2_word, 32'h00007402);

        applyStimulus(8'h1C, 1'b0);
        drain("letter_a");
`ifdef PS2_KBD_WASD_EN
        checkOutput("letter_a_word", bus.ps2_word, 32'h00001C03);
`else
        checkOutput("letter_a_word", bus.ps2_word, 32'h00001C02);
`endif
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h1C, 1'b0);
        drain("letter_a_break");
        checkOutput("letter_a_break_word", bus.ps2_word, 32'h00001C02);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
